// File: rtl/cg_pkg.sv
`default_nettype none
// ============================================================================
// Package : cg_pkg
// Shared types and helpers for the clock-gating enable controller.
// Rev     : 1.0
// ============================================================================
package cg_pkg;

  localparam int CG_CNT_W = 16;

  typedef enum logic [1:0] {
    SLEEP = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2
  } cg_state_t;

  function automatic logic [CG_CNT_W-1:0] cg_sat_inc(input logic [CG_CNT_W-1:0] v);
    logic [CG_CNT_W-1:0] one;
    one = 1;
    return (v == '1) ? v : v + one;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cg_hold_timer.sv
`default_nettype none
// ============================================================================
// Module : cg_hold_timer
// Loadable down-counter; expire flags the final counted cycle (count == 1).
// Rev    : 1.0
// ============================================================================
module cg_hold_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == ONE);

endmodule
`default_nettype wire

// File: rtl/cg_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cg_enable_ctrl
// Activity-driven enable for the multiplier clock gate, with gating statistics.
// Rev    : 1.0
// ============================================================================
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int                  WIDTH        = 8,
  parameter int                  WAKE_CYCLES  = 1,
  parameter int                  PIPE_DEPTH   = 2,
  parameter int                  IDLE_TIMEOUT = 4,
  parameter logic [CG_CNT_W-1:0] STAT_INIT    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic                in_ready,
  output logic                cg_enable,
  output logic                mult_valid,
  output logic [WIDTH-1:0]    mult_a,
  output logic [WIDTH-1:0]    mult_b,
  output logic                busy,
  output logic [CG_CNT_W-1:0] gated_cycles,
  output logic [CG_CNT_W-1:0] wake_count
);

  localparam int HOLD_CYCLES = PIPE_DEPTH + IDLE_TIMEOUT;
  localparam int WAKE_W      = $clog2(WAKE_CYCLES + 1);
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  cg_state_t state_q, state_d;

  logic cg_enable_q, cg_enable_d;
  logic in_ready_q, in_ready_d;
  logic busy_q, busy_d;
  logic mult_valid_q, mult_valid_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [CG_CNT_W-1:0] gated_q, gated_d, wakes_q, wakes_d;

  logic xfer;
  logic wake_load, wake_dec, wake_expire;
  logic hold_load, hold_dec, hold_expire;
  logic wake_done;

  // in_ready_q is exactly what upstream sees, so the handshake uses it directly.
  assign xfer      = in_valid && in_ready_q;
  assign wake_load = (state_q == SLEEP) && xfer;
  assign wake_dec  = (state_q == WAKE);
  assign wake_done = (state_q == WAKE) && wake_expire;
  assign hold_load = wake_done || ((state_q == ON) && xfer);
  assign hold_dec  = (state_q == ON) && !xfer;

  cg_hold_timer #(
    .CNT_W (WAKE_W)
  ) u_wake_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wake_load),
    .load_val (WAKE_LOAD),
    .dec      (wake_dec),
    .expire   (wake_expire)
  );

  cg_hold_timer #(
    .CNT_W (HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (hold_dec),
    .expire   (hold_expire)
  );

  // Status outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLEEP:   if (xfer) state_d = WAKE;
      WAKE:    if (wake_expire) state_d = ON;
      ON:      if (!xfer && hold_expire) state_d = SLEEP;
      default: state_d = SLEEP;
    endcase
    cg_enable_d = (state_d != SLEEP);
    busy_d      = (state_d != SLEEP);
    in_ready_d  = (state_d != WAKE);
  end

  always_comb begin
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    mult_valid_d = 1'b0;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    if (wake_load) begin
      cap_a_d = in_a;
      cap_b_d = in_b;
    end
    if (wake_done) begin
      mult_valid_d = 1'b1;
      mult_a_d     = cap_a_q;
      mult_b_d     = cap_b_q;
    end else if ((state_q == ON) && xfer) begin
      mult_valid_d = 1'b1;
      mult_a_d     = in_a;
      mult_b_d     = in_b;
    end
    gated_d = cg_enable_q ? gated_q : cg_sat_inc(gated_q);
    wakes_d = wake_load ? cg_sat_inc(wakes_q) : wakes_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SLEEP;
      cg_enable_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      mult_valid_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      gated_q      <= STAT_INIT;
      wakes_q      <= STAT_INIT;
    end else begin
      state_q      <= state_d;
      cg_enable_q  <= cg_enable_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      mult_valid_q <= mult_valid_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      gated_q      <= gated_d;
      wakes_q      <= wakes_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign cg_enable    = cg_enable_q;
  assign busy         = busy_q;
  assign mult_valid   = mult_valid_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign gated_cycles = gated_q;
  assign wake_count   = wakes_q;

endmodule
`default_nettype wire

// File: doc/cg_enable_ctrl.md
# cg_enable_ctrl

Activity-driven controller that produces the `enable` input of `clock_gating_cell` for the approximate multiplier datapath. It accepts operand pairs from upstream and wakes the gated clock domain, paying a fixed wake latency. It issues registered operands to the multiplier and keeps the clock running until the multiplier pipeline drains and an idle timeout expires. It then drops `enable` and counts the gated cycles for power reporting.

## Interface
- `WIDTH`, 8, operand width
- `WAKE_CYCLES`, 1, cycles `cg_enable` is high before the first issue (≥1)
- `PIPE_DEPTH`, 2, multiplier pipeline latency in gated cycles (≥0)
- `IDLE_TIMEOUT`, 4, extra idle cycles after drain before gating (≥0); `PIPE_DEPTH+IDLE_TIMEOUT` ≥ 1
- `clk`  in  1  free-running clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream operand pair valid
- `in_a`, `in_b`  in  WIDTH  operands
- `in_ready`  out  1  controller can accept this cycle
- `cg_enable`  out  1  to `clock_gating_cell.enable`
- `mult_valid`  out  1  one-cycle issue strobe to the multiplier
- `mult_a`, `mult_b`  out  WIDTH  registered operands, valid with `mult_valid`
- `busy`  out  1  state ≠ SLEEP
- `gated_cycles`  out  16  saturating count of cycles with `cg_enable`=0
- `wake_count`  out  16  saturating count of SLEEP→WAKE transitions

## Operation
- Constant H = PIPE_DEPTH + IDLE_TIMEOUT.
- A transfer occurs when `in_valid` and `in_ready` are both 1 at a rising edge.
- States are SLEEP, WAKE and ON. All outputs are registered.
- SLEEP: `cg_enable`=0 and `in_ready`=1.
  - On transfer: capture operands, load wake counter with WAKE_CYCLES, go to WAKE, increment `wake_count`.
- WAKE: `cg_enable`=1 and `in_ready`=0. Upstream must hold `in_valid`/data, and nothing is accepted.
  - Counter decrements every cycle. At count 1, go to ON and assert `mult_valid` with the captured operands in the first ON cycle. Load the hold counter with H.
- ON: `cg_enable`=1 and `in_ready`=1.
  - On transfer: `mult_a`/`mult_b` take the inputs and `mult_valid`=1 in the next cycle. Reload the hold counter with H.
  - With no transfer, the hold counter decrements. At count 1 with no transfer, go to SLEEP.
- A transfer in the same cycle the hold counter reaches 1 takes priority: reload to H and stay in ON.
- `mult_a`/`mult_b` retain their last value when `mult_valid`=0.
- `gated_cycles` increments in each cycle where `cg_enable`=0. `wake_count` increments per wake. Both counters saturate at 16'hFFFF with no wrap.
- Reset, including mid-WAKE or mid-ON: any captured operand is discarded, no `mult_valid` is issued, and the block returns to SLEEP.

## Timing
- Reset values: state SLEEP, `cg_enable`=0, `in_ready`=1, `mult_valid`=0, `mult_a`=`mult_b`=0, `busy`=0, both counters 0.
- Transfer in SLEEP at edge 0:
  - `cg_enable`=1 in cycles 1..WAKE_CYCLES+H.
  - `mult_valid` in cycle WAKE_CYCLES+1.
  - `in_ready`=0 in cycles 1..WAKE_CYCLES.
  - These hold when no further transfers occur.
- Transfer in ON at edge k: `mult_valid` in cycle k+1. `cg_enable` stays high through cycle k+H at least.
- Back-to-back transfers in ON give one `mult_valid` per cycle, so throughput is 1/cycle.
- `cg_enable` changes only right after rising edges. `clock_gating_cell` latches it during clk-low, so the gated clock follows one cycle later. WAKE_CYCLES covers this delay.

## Structure
- Package `cg_pkg`:
  - state enum `cg_state_t` {SLEEP, WAKE, ON}
  - counter width constant `CG_CNT_W`=16
  - helper function for the saturating increment
- Sub-module `cg_hold_timer`: loadable down-counter with reload/decrement/`expire` output, used for both the wake and hold counters.
- Top-level: FSM, operand registers, statistics counters.

## Test plan
All scenarios use default parameters (H=6).
- Reset then idle 10 cycles → `cg_enable`=0, `in_ready`=1, `gated_cycles`=10, `wake_count`=0.
- Single transfer a=8'h05, b=8'h07 at edge 0 in SLEEP:
  - `cg_enable` high cycles 1–7.
  - `in_ready`=0 in cycle 1.
  - `mult_valid` with 05/07 in cycle 2.
  - SLEEP from cycle 8, `wake_count`=1.
- Four back-to-back transfers while ON → four consecutive `mult_valid` pulses with matching operands in order. `cg_enable` drops 6 cycles after the last accept.
- Transfer in the exact cycle the hold counter is 1 → no SLEEP entry, `cg_enable` stays high, `wake_count` unchanged.
- `in_valid` held during WAKE with changing data → only the SLEEP-cycle operands are issued, and the held data is accepted in the first ON cycle.
- Reset asserted mid-WAKE → no `mult_valid` ever, `cg_enable`=0 immediately (asynchronous), and the counters are preloaded near 16'hFFFF to confirm saturation.
